// File: rtl/mpq_cmd_sched.sv
// Round-robin scheduler that feeds A/B command FIFOs (2 deep each) to the priority-queue engine, one command at a time.
// Issue one cycle after a push lands in an idle scheduler; x_ready is low while that requester's FIFO holds two entries.

module mpq_fifo2 #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         not_empty,
    output logic         ready
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    assign head      = mem[rd_ptr];
    assign not_empty = (count != 2'd0);
    // count never exceeds 2, so bit 1 alone marks full
    assign ready     = ~count[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

module mpq_cmd_sched #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic [2:0] a_cmd,
    input  logic [7:0] a_index,
    input  logic [7:0] a_value,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [2:0] b_cmd,
    input  logic [7:0] b_index,
    input  logic [7:0] b_value,
    output logic       b_ready,
    input  logic       mpq_busy,
    input  logic       mpq_done,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic [7:0] index,
    output logic [7:0] value,
    output logic       grant_id,
    output logic       cmd_complete,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t      state;
    logic        last_grant;
    logic [3:0]  cnt;
    logic        a_hs, b_hs, a_push, b_push, a_pop, b_pop, a_ne, b_ne, pick_b;
    logic [18:0] a_head, b_head, pick_head;

    assign a_hs   = a_valid & a_ready;
    assign b_hs   = b_valid & b_ready;
    // codes 5..7 complete the handshake but are dropped here and flagged via err
    assign a_push = a_hs & (a_cmd <= 3'd4);
    assign b_push = b_hs & (b_cmd <= 3'd4);
    assign a_pop  = (state == ISSUE) & ~grant_id;
    assign b_pop  = (state == ISSUE) & grant_id;

    // B wins only if A is empty or A was served last
    assign pick_b    = b_ne & (~a_ne | ~last_grant);
    assign pick_head = pick_b ? b_head : a_head;

    mpq_fifo2 #(.W(19)) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (a_push),
        .push_dat  ({a_cmd, a_index, a_value}),
        .pop       (a_pop),
        .head      (a_head),
        .not_empty (a_ne),
        .ready     (a_ready)
    );

    mpq_fifo2 #(.W(19)) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (b_push),
        .push_dat  ({b_cmd, b_index, b_value}),
        .pop       (b_pop),
        .head      (b_head),
        .not_empty (b_ne),
        .ready     (b_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            cnt          <= 4'd0;
            cmd_valid    <= 1'b0;
            cmd          <= 3'd0;
            index        <= 8'd0;
            value        <= 8'd0;
            grant_id     <= 1'b0;
            cmd_complete <= 1'b0;
            err          <= 1'b0;
        end else begin
            cmd_valid    <= 1'b0;
            cmd_complete <= 1'b0;
            err          <= (a_hs & (a_cmd > 3'd4)) | (b_hs & (b_cmd > 3'd4));
            case (state)
                IDLE: begin
                    if (a_ne | b_ne) begin
                        grant_id              <= pick_b;
                        {cmd, index, value}   <= pick_head;
                        cmd_valid             <= 1'b1;
                        state                 <= ISSUE;
                    end
                end
                ISSUE: begin
                    last_grant <= grant_id;
                    cnt        <= 4'd0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (mpq_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == 4'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                WAIT_DONE: begin
                    // writes finish on the RAM write-out, everything else on busy falling
                    if ((cmd == 3'd4) ? mpq_done : ~mpq_busy) begin
                        cmd_complete <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mpq_cmd_sched.md
MPQ_CMD_SCHED -- requirements
Module: mpq_cmd_sched

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the max cycles to wait for mpq_busy after a command issue (legal 1..15).
REQ-002 The block SHALL have the following ports, one per line:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- a_valid  in  1  requester A command strobe.
- a_cmd  in  3  requester A command code.
- a_index  in  8  requester A index.
- a_value  in  8  requester A value.
- a_ready  out  1  requester A FIFO not full.
- b_valid  in  1  requester B command strobe.
- b_cmd  in  3  requester B command code.
- b_index  in  8  requester B index.
- b_value  in  8  requester B value.
- b_ready  out  1  requester B FIFO not full.
- mpq_busy  in  1  priority-queue engine busy.
- mpq_done  in  1  priority-queue engine RAM write-out finished.
- cmd_valid  out  1  one-cycle command strobe to the engine.
- cmd  out  3  command code to the engine.
- index  out  8  index to the engine.
- value  out  8  value to the engine.
- grant_id  out  1  owner of the in-flight command; 0=A, 1=B.
- cmd_complete  out  1  one-cycle pulse when the in-flight command finishes.
- err  out  1  one-cycle pulse on an illegal code or a timeout.

Function
REQ-003 Legal command codes SHALL be: 0 build, 1 extract-max, 2 increase-value, 3 insert, 4 write.
REQ-004 Each requester SHALL have a 2-entry FIFO of {cmd, index, value}.
REQ-005 x_ready SHALL equal "FIFO count < 2" and SHALL NOT depend on a same-cycle pop.
REQ-006 A push SHALL occur when x_valid and x_ready are both high.
REQ-007 A valid code 5..7 SHALL be accepted (handshake completes) but not stored, and err SHALL pulse the next cycle.
REQ-008 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-009 In IDLE, if any FIFO is non-empty, the FSM SHALL select a requester and go to ISSUE next cycle.
REQ-010 Selection SHALL be round-robin: if both FIFOs are non-empty, select the one not granted last; if only one is non-empty, select it.
REQ-011 last_grant SHALL reset to B, so A wins the first tie.
REQ-012 In ISSUE, cmd_valid SHALL be high for exactly one cycle with cmd/index/value equal to the selected FIFO head.
REQ-013 The head SHALL be popped in the ISSUE cycle, grant_id and last_grant SHALL be updated, and the FSM SHALL go to WAIT_BUSY.
REQ-014 Latency: a push into an empty FIFO at edge t while the FSM is IDLE SHALL produce cmd_valid in the cycle after edge t+1.
REQ-015 WAIT_BUSY SHALL run a 4-bit counter cleared on entry.
REQ-016 In WAIT_BUSY, mpq_busy=1 SHALL move the FSM to WAIT_DONE.
REQ-017 In WAIT_BUSY, if the counter reaches TIMEOUT with mpq_busy still 0, err SHALL pulse and the FSM SHALL return to IDLE without a cmd_complete pulse.
REQ-018 In WAIT_DONE for codes 0..3: mpq_busy=0 SHALL pulse cmd_complete and return the FSM to IDLE.
REQ-019 In WAIT_DONE for code 4: the FSM SHALL ignore mpq_busy, wait for mpq_done=1, then pulse cmd_complete and return to IDLE.
REQ-020 Only one command SHALL be in flight at a time; cmd_valid SHALL never assert outside ISSUE.
REQ-021 Pushes SHALL be accepted in every state while the FIFO is not full.
REQ-022 cmd, index, value and grant_id SHALL hold their last issued values until the next ISSUE.
REQ-023 All outputs SHALL be registered.
REQ-024 Simultaneous push and pop on one FIFO with count=1 SHALL leave count=1 with correct ordering.

Reset
REQ-025 On rst, the FSM SHALL go to IDLE and both FIFOs SHALL be emptied.
REQ-026 On rst, last_grant SHALL be B and the counter SHALL be 0.
REQ-027 On rst, cmd_valid, cmd_complete and err SHALL be 0.
REQ-028 On rst, cmd, index, value and grant_id SHALL be 0.
REQ-029 On rst, a_ready and b_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-030 A reset mid-command SHALL abandon the command with no cmd_complete or err pulse.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- Single A push {3,8'h05,8'h40} into idle -> cmd_valid in the cycle after edge t+1 with cmd=3, index=5, value=0x40, grant_id=0; busy high 3 cycles then low -> one cmd_complete.
- A and B both push in the same cycle -> A issued first, then B, then A's second entry; grant_id sequence 0,1,0.
- Three A pushes back-to-back while the engine is busy -> a_ready low after two; third accepted only after the first pop.
- Code 6 pushed -> handshake completes, err pulses once, no cmd_valid.
- Write (4) issued, mpq_busy falls, mpq_done asserts 5 cycles later -> cmd_complete only on the mpq_done cycle.
- TIMEOUT=3 and mpq_busy never rises -> err pulses on the 3rd WAIT_BUSY cycle; next queued command issues normally.
- rst asserted in WAIT_DONE with both FIFOs full -> all outputs reset, FIFOs empty, no pulses.
